// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: datapath widths, NOP encoding and the fetch FIFO entry.
package mips_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; pointers wrap mod DEPTH.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push;
  assign count   = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      // Flush wins over any push; a concurrent pop is simply consumed by the clear.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_comb begin
    rdata = '{pc: '0, instr: NOP};
    if (!empty) rdata = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: credit-based issue to a 1-cycle synchronous imem, inflight tracking, and a
// small FIFO toward decode; drives PC hold as backpressure and drops wrong-path work on flush.
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_hold,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;

  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              pop, push, issue;
  logic [OCC_W-1:0]  occ_after_pop;
  fetch_entry_t      head, wentry;

  assign pop    = if_valid & id_ready;
  assign push   = inflight_q & ~kill_q;
  assign wentry = '{pc: inflight_pc_q, instr: imem_rdata};

  // Count the inflight read as an occupied slot so its return always has room.
  assign occ_after_pop = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue         = ~reset & ~flush & (occ_after_pop < OCC_W'(DEPTH));

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  always_comb begin
    inflight_d    = issue;
    inflight_pc_d = issue ? pc : inflight_pc_q;
    kill_d        = flush & inflight_q;
  end

  always_comb begin
    imem_en   = issue;
    imem_addr = pc;
    pc_hold   = ~issue & ~flush & ~reset;
    if_valid  = ~empty;
    if_instr  = head.instr;
    if_pc     = head.pc;
  end

  push_into_full : assert property (@(posedge clock) disable iff (reset) !(push && full && !flush));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios then random traffic, checked every cycle
// against a queue-level model of the fetch pipeline.
module tb_instr_fetch_stage;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc;
  logic              pc_hold;
  logic              flush;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  instr_fetch_stage #(
    .DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pc_hold    (pc_hold),
    .flush      (flush),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready)
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory, 1-cycle read latency.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clock) if (imem_en) imem_rdata <= mem[imem_addr];

  fetch_entry_t      q [$];
  bit                m_infl;
  logic [ADDR_W-1:0] m_infl_pc;
  int                n_vec = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model and PC.
  task automatic step(input logic fl, input logic rdy, input logic [ADDR_W-1:0] tgt);
    bit                e_valid, e_pop, e_issue;
    logic [ADDR_W-1:0] nxt_pc;
    flush    = fl;
    id_ready = rdy;
    #1;
    e_valid = (q.size() > 0);
    e_pop   = e_valid && rdy;
    e_issue = !fl && ((int'(q.size()) + int'(m_infl) - int'(e_pop)) < DEPTH);
    chk("if_valid", if_valid, e_valid);
    if (e_valid) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end
    chk("imem_en", imem_en, e_issue);
    if (e_issue) chk("imem_addr", imem_addr, pc);
    chk("pc_hold", pc_hold, !e_issue && !fl);
    if (fl) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (m_infl) q.push_back('{pc: m_infl_pc, instr: mem[m_infl_pc]});
    end
    m_infl    = e_issue;
    m_infl_pc = pc;
    nxt_pc    = fl ? tgt : (e_issue ? pc + 8'd4 : pc);
    @(negedge clock);
    pc = nxt_pc;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset    = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    pc       = 8'h00;
    m_infl   = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_imem_en", imem_en, 0);
    chk("rst_pc_hold", pc_hold, 0);
    reset = 1'b0;

    // Streaming from pc 0x00.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stream_if_pc", if_pc, 32'(i * 4));
      chk("stream_pc_hold", pc_hold, 0);
      step(1'b0, 1'b1, 8'h00);
    end
    repeat (2) step(1'b0, 1'b1, 8'h00);

    // Decode stall, then ordered drain.
    repeat (4) step(1'b0, 1'b0, 8'h00);
    #1;
    chk("stall_pc_hold", pc_hold, 1);
    repeat (6) step(1'b0, 1'b1, 8'h00);

    // Flush while stalled with a read in flight.
    step(1'b0, 1'b0, 8'h00);
    flush = 1'b1;
    #1;
    chk("flush_imem_en", imem_en, 0);
    step(1'b1, 1'b0, 8'h40);
    repeat (2) step(1'b0, 1'b1, 8'h00);
    #1;
    chk("flush_tgt_valid", if_valid, 1);
    chk("flush_tgt_pc", if_pc, 8'h40);
    repeat (3) step(1'b0, 1'b1, 8'h00);

    // Flush coinciding with a pop.
    repeat (2) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h80);
    repeat (5) step(1'b0, 1'b1, 8'h00);

    // PC wrap 0xFC -> 0x00.
    step(1'b1, 1'b1, 8'hF4);
    repeat (4) step(1'b0, 1'b1, 8'h00);
    #1;
    chk("wrap_pc_fc", if_pc, 8'hFC);
    chk("wrap_instr_fc", if_instr, mem[8'hFC]);
    step(1'b0, 1'b1, 8'h00);
    #1;
    chk("wrap_pc_00", if_pc, 8'h00);
    chk("wrap_instr_00", if_instr, mem[8'h00]);
    repeat (3) step(1'b0, 1'b1, 8'h00);

    // Reset mid-stream with two entries buffered.
    repeat (3) step(1'b0, 1'b0, 8'h00);
    #1;
    chk("pre_rst_valid", if_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_if_valid", if_valid, 0);
    chk("mid_rst_imem_en", imem_en, 0);
    chk("mid_rst_pc_hold", pc_hold, 0);
    @(negedge clock);
    q.delete();
    m_infl = 1'b0;
    pc     = 8'h20;
    reset  = 1'b0;
    repeat (2) step(1'b0, 1'b1, 8'h00);
    #1;
    chk("post_rst_pc", if_pc, 8'h20);
    step(1'b0, 1'b1, 8'h00);

    // Random traffic.
    repeat (400) begin
      logic              r_fl, r_rdy;
      logic [ADDR_W-1:0] r_tgt;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 15) == 0);
      r_tgt = 8'($urandom) & 8'hFC;
      step(r_fl, r_rdy, r_tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
